// File: rtl/dec_pkg.sv
// dec_pkg: state encoding, mode constants and clog2 helper for dec_scan_n
package dec_pkg;
  typedef enum logic [1:0] {S_OFF = 2'd0, S_DIRECT = 2'd1, S_SCAN = 2'd2} state_t;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/dec_onehot.sv
// dec_onehot: combinational SEL_W-to-2**SEL_W one-hot decoder with enable
module dec_onehot #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  output logic [2**SEL_W-1:0] lines
);
  assign lines = {{(2**SEL_W-1){1'b0}}, en} << sel;
endmodule

// File: rtl/dec_scan_n.sv
// dec_scan_n: registered N-to-2^N one-hot decoder with direct and auto-scan modes
module dec_scan_n
  import dec_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int PRESCALE   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    inp,
  output logic [2**SEL_W-1:0] out,
  output logic [SEL_W-1:0]    idx,
  output logic                valid,
  output logic                wrap
);
  localparam int N = 2**SEL_W;
  localparam int PW = clog2(PRESCALE) < 1 ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  state_t state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [SEL_W-1:0] idx_n;
  logic [N-1:0] lines;
  logic held, step, wrap_n;
  // held: current idx already shown in scan, so presc == 0 means its dwell is complete
  always_comb begin
    state_n = !en ? S_OFF : mode == MODE_SCAN ? S_SCAN : S_DIRECT;
    step = state_n == S_SCAN && held && presc == '0;
    idx_n = state_n == S_DIRECT ? inp : step ? idx + 1'b1 : idx;
    presc_n = state_n == S_SCAN ? (presc == P_LAST ? '0 : presc + 1'b1) :
              state_n == S_DIRECT ? '0 : presc;
    wrap_n = step && idx == '1;
  end
  dec_onehot #(.SEL_W(SEL_W)) u_onehot (
    .sel   (idx_n),
    .en    (state_n != S_OFF),
    .lines (lines)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_OFF;
      presc <= '0;
      idx   <= '0;
      held  <= 1'b0;
      wrap  <= 1'b0;
      out   <= {N{ACTIVE_LOW}};
    end else begin
      state <= state_n;
      presc <= presc_n;
      idx   <= idx_n;
      held  <= state_n == S_SCAN ? 1'b1 : state_n == S_DIRECT ? 1'b0 : held;
      wrap  <= wrap_n;
      out   <= lines ^ {N{ACTIVE_LOW}};
    end
  end
  // the unused encoding 2'd3 decodes as off
  assign valid = state == S_DIRECT || state == S_SCAN;
endmodule

// File: tb/tb_dec_scan_n.sv
// tb_dec_scan_n: model-checked bench for two dec_scan_n configurations
module tb_dec_scan_n;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, mode = 1'b1;
  logic [2:0] inp = 3'd0;
  logic [7:0] out0, out1;
  logic [2:0] idx0, idx1;
  logic valid0, valid1, wrap0, wrap1;
  int checks = 0, errors = 0;
  bit live = 1'b0;
  int m_idx[2], m_cnt[2];
  bit m_v[2], m_w[2];
  always #5 clk = ~clk;
  dec_scan_n #(.SEL_W(3), .PRESCALE(4), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inp(inp),
    .out(out0), .idx(idx0), .valid(valid0), .wrap(wrap0)
  );
  dec_scan_n #(.SEL_W(3), .PRESCALE(1), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inp(inp),
    .out(out1), .idx(idx1), .valid(valid1), .wrap(wrap1)
  );
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  // model: m_cnt counts scan cycles the current index has been shown
  task automatic model(input int k, input int p);
    if (!rst_n) begin
      m_idx[k] = 0; m_cnt[k] = 0; m_v[k] = 0; m_w[k] = 0;
    end else if (!en) begin
      m_v[k] = 0; m_w[k] = 0;
    end else if (!mode) begin
      m_idx[k] = int'(inp); m_cnt[k] = 0; m_v[k] = 1; m_w[k] = 0;
    end else begin
      m_v[k] = 1;
      m_w[k] = m_cnt[k] == p && m_idx[k] == 7;
      if (m_cnt[k] == p) begin
        m_idx[k] = (m_idx[k] + 1) % 8;
        m_cnt[k] = 1;
      end else m_cnt[k]++;
    end
  endtask
  function automatic logic [7:0] exp_out(input int k);
    logic [7:0] o;
    o = m_v[k] ? 8'(1 << m_idx[k]) : 8'h00;
    return k == 1 ? ~o : o;
  endfunction
  always @(posedge clk) begin
    model(0, 4);
    model(1, 1);
  end
  always @(negedge clk) begin
    if (live) begin
      chk("out0", out0, exp_out(0));
      chk("idx0", 8'(idx0), 8'(m_idx[0]));
      chk("valid0", 8'(valid0), 8'(m_v[0]));
      chk("wrap0", 8'(wrap0), 8'(m_w[0]));
      chk("out1", out1, exp_out(1));
      chk("idx1", 8'(idx1), 8'(m_idx[1]));
      chk("valid1", 8'(valid1), 8'(m_v[1]));
      chk("wrap1", 8'(wrap1), 8'(m_w[1]));
    end
  end
  initial begin
    cyc(2);
    live = 1'b1;
    chk("rst_out", out0, 8'h00);
    chk("rst_idx", 8'(idx0), 8'd0);
    chk("rst_valid", 8'(valid0), 8'd0);
    chk("rst_wrap", 8'(wrap0), 8'd0);
    chk("rst_out_al", out1, 8'hFF);
    rst_n = 1'b1; en = 1'b1; mode = 1'b0; inp = 3'd5;
    cyc(1);
    chk("dir_out", out0, 8'h20);
    chk("dir_idx", 8'(idx0), 8'd5);
    chk("dir_valid", 8'(valid0), 8'd1);
    chk("dir_out_al", out1, 8'hDF);
    en = 1'b0;
    cyc(1);
    chk("off_out", out0, 8'h00);
    chk("off_valid", 8'(valid0), 8'd0);
    chk("off_idx", 8'(idx0), 8'd5);
    rst_n = 1'b0; cyc(1); rst_n = 1'b1; en = 1'b1; mode = 1'b1;
    cyc(4);
    chk("scan_01", out0, 8'h01);
    cyc(1);
    chk("scan_02", out0, 8'h02);
    cyc(27);
    chk("scan_80", out0, 8'h80);
    chk("scan_nowrap", 8'(wrap0), 8'd0);
    cyc(1);
    chk("wrap_01", out0, 8'h01);
    chk("wrap_pulse", 8'(wrap0), 8'd1);
    cyc(1);
    chk("wrap_end", 8'(wrap0), 8'd0);
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    cyc(14);
    chk("pre_pause", out0, 8'h08);
    en = 1'b0;
    cyc(1);
    chk("pause_out", out0, 8'h00);
    chk("pause_valid", 8'(valid0), 8'd0);
    chk("pause_idx", 8'(idx0), 8'd3);
    cyc(2);
    en = 1'b1;
    cyc(2);
    chk("resume_08", out0, 8'h08);
    cyc(1);
    chk("resume_10", out0, 8'h10);
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    cyc(25);
    chk("scan_idx6", out0, 8'h40);
    mode = 1'b0; inp = 3'd1;
    cyc(1);
    chk("sw_out", out0, 8'h02);
    chk("sw_idx", 8'(idx0), 8'd1);
    mode = 1'b1;
    cyc(4);
    chk("sw_hold", out0, 8'h02);
    cyc(1);
    chk("sw_next", out0, 8'h04);
    rst_n = 1'b0;
    cyc(1);
    chk("al_rst", out1, 8'hFF);
    rst_n = 1'b1; mode = 1'b0; inp = 3'd0;
    cyc(1);
    chk("al_dir", out1, 8'hFE);
    mode = 1'b1;
    cyc(1);
    chk("al_scan_hold", out1, 8'hFE);
    cyc(1);
    chk("al_fd", out1, 8'hFD);
    cyc(1);
    chk("al_fb", out1, 8'hFB);
    rst_n = 1'b0;
    cyc(1);
    chk("al_midrst", out1, 8'hFF);
    chk("al_idx", 8'(idx1), 8'd0);
    repeat (3000) begin
      rst_n = $urandom_range(0, 49) != 0;
      en = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      inp = 3'($urandom);
      cyc(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
